// File: rtl/piso_pkg.sv
// Shared types and helpers for the parametrised PISO shift register.
package piso_pkg;

  typedef enum logic {
    PISO_IDLE  = 1'b0,
    PISO_SHIFT = 1'b1
  } piso_state_e;

  // Counter must be able to hold FLEN itself (the post-frame count).
  function automatic int unsigned piso_cnt_w(input int unsigned flen);
    return $clog2(flen + 1);
  endfunction

endpackage

// File: rtl/piso_shift_param_bit_cnt.sv
// Frame bit counter: synchronous clear, count enable, flag on the last bit of a frame.
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int unsigned FLEN = 8,
  parameter int unsigned CW   = piso_cnt_w(FLEN)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)      r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + CW'(1);
  end

  assign o_last = (r_cnt == CW'(FLEN - 1));

endmodule

// File: rtl/piso_shift_param.sv
// Parallel-in/serial-out shifter with valid/ready load and shift_en back-pressure.
// Optional macro PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_shift_param
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_last
);

`ifdef PISO_PARITY_EN
  localparam int unsigned FLEN = WIDTH + 1;
`else
  localparam int unsigned FLEN = WIDTH;
`endif

  piso_state_e     r_state, w_state_nxt;
  logic [FLEN-1:0] r_shift;
  logic [FLEN-1:0] w_load_word;
  logic [FLEN-1:0] w_shifted;
  logic            w_sv;
  logic            w_cnt_last;
  logic            w_last;
  logic            w_accept;
  logic            w_advance;

  assign w_sv       = (r_state == PISO_SHIFT);
  assign w_last     = w_sv && w_cnt_last;
  assign load_ready = !w_sv || (w_last && shift_en);
  assign w_accept   = load_valid && load_ready;
  assign w_advance  = w_sv && shift_en;

  // Parity sits at the trailing end of the register so it falls out after the data.
  always_comb begin
`ifdef PISO_PARITY_EN
    if (MSB_FIRST) w_load_word = {parallel_in, ^parallel_in};
    else           w_load_word = {^parallel_in, parallel_in};
`else
    w_load_word = parallel_in;
`endif
  end

  assign w_shifted = MSB_FIRST ? {r_shift[FLEN-2:0], 1'b0} : {1'b0, r_shift[FLEN-1:1]};

  always_ff @(posedge clk) begin
    if (reset)          r_shift <= '0;
    else if (w_accept)  r_shift <= w_load_word;
    else if (w_advance) r_shift <= w_shifted;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= PISO_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PISO_IDLE:  if (w_accept) w_state_nxt = PISO_SHIFT;
      PISO_SHIFT: if (shift_en && w_last && !w_accept) w_state_nxt = PISO_IDLE;
      default:    w_state_nxt = PISO_IDLE;
    endcase
  end

  piso_bit_cnt #(
    .FLEN (FLEN)
  ) u_bit_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_accept),
    .i_en   (w_advance),
    .o_last (w_cnt_last)
  );

  assign serial_valid = w_sv;
  assign serial_out   = w_sv && (MSB_FIRST ? r_shift[FLEN-1] : r_shift[0]);
  assign frame_last   = w_last;

endmodule

// File: tb/tb_piso_shift_param.sv
// Directed bench for piso_shift_param: one MSB-first and one LSB-first instance.
module tb_piso_shift_param;

  localparam int unsigned W = 8;
`ifdef PISO_PARITY_EN
  localparam int unsigned FL = W + 1;
`else
  localparam int unsigned FL = W;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a_pin, b_pin;
  logic         a_lv, a_lr, a_se, a_so, a_sv, a_fl;
  logic         b_lv, b_lr, b_se, b_so, b_sv, b_fl;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  piso_shift_param #(.WIDTH(W), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .reset(reset), .parallel_in(a_pin), .load_valid(a_lv), .load_ready(a_lr),
    .shift_en(a_se), .serial_out(a_so), .serial_valid(a_sv), .frame_last(a_fl)
  );

  piso_shift_param #(.WIDTH(W), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .reset(reset), .parallel_in(b_pin), .load_valid(b_lv), .load_ready(b_lr),
    .shift_en(b_se), .serial_out(b_so), .serial_valid(b_sv), .frame_last(b_fl)
  );

  // Expected bit i of a frame: data in the chosen order, then even parity if enabled.
  function automatic logic exp_bit(input logic [W-1:0] w, input int unsigned i, input bit msb);
    if (i >= W) return ^w;
    return msb ? w[W-1-i] : w[i];
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sel=0 drives the MSB-first instance, sel=1 the LSB-first one.
  task automatic load(input bit sel, input logic [W-1:0] w, input string tag);
    if (sel) begin b_pin = w; b_lv = 1'b1; b_se = 1'b1; end
    else     begin a_pin = w; a_lv = 1'b1; a_se = 1'b1; end
    #1;
    chk({tag, "_ready"}, sel ? b_lr : a_lr, 1'b1);
    step();
    if (sel) b_lv = 1'b0; else a_lv = 1'b0;
  endtask

  task automatic frame(input bit sel, input logic [W-1:0] w, input string tag);
    for (int unsigned i = 0; i < FL; i++) begin
      #1;
      chk($sformatf("%s_bit%0d", tag, i), sel ? b_so : a_so, exp_bit(w, i, !sel));
      chk($sformatf("%s_valid%0d", tag, i), sel ? b_sv : a_sv, 1'b1);
      chk($sformatf("%s_last%0d", tag, i), sel ? b_fl : a_fl, (i == FL - 1));
      step();
    end
    #1;
    chk({tag, "_end_valid"}, sel ? b_sv : a_sv, 1'b0);
    chk({tag, "_end_out"}, sel ? b_so : a_so, 1'b0);
    chk({tag, "_end_ready"}, sel ? b_lr : a_lr, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    a_pin = '0; a_lv = 1'b0; a_se = 1'b0;
    b_pin = '0; b_lv = 1'b0; b_se = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_out", a_so, 1'b0);
    chk("rst_valid", a_sv, 1'b0);
    chk("rst_last", a_fl, 1'b0);
    chk("rst_ready", a_lr, 1'b1);

    // MSB first: 8'h1E -> 0,0,0,1,1,1,1,0
    load(1'b0, 8'h1E, "msb");
    frame(1'b0, 8'h1E, "msb");

    // LSB first: 8'h1E -> 0,1,1,1,1,0,0,0
    load(1'b1, 8'h1E, "lsb");
    frame(1'b1, 8'h1E, "lsb");

    // Stall three cycles while the second bit is presented
    load(1'b0, 8'h1E, "stall");
    for (int unsigned i = 0; i < FL; i++) begin
      if (i == 1) begin
        for (int unsigned s = 0; s < 3; s++) begin
          a_se = 1'b0;
          #1;
          chk($sformatf("stall_hold_out%0d", s), a_so, 1'b0);
          chk($sformatf("stall_hold_valid%0d", s), a_sv, 1'b1);
          chk($sformatf("stall_hold_ready%0d", s), a_lr, 1'b0);
          step();
        end
      end
      a_se = 1'b1;
      #1;
      chk($sformatf("stall_bit%0d", i), a_so, exp_bit(8'h1E, i, 1'b1));
      chk($sformatf("stall_last%0d", i), a_fl, (i == FL - 1));
      step();
    end
    #1;
    chk("stall_end_valid", a_sv, 1'b0);

    // Back-to-back: load_valid held, second word taken on the last-bit edge
    a_pin = 8'h1E; a_lv = 1'b1; a_se = 1'b1;
    #1;
    chk("b2b_ready0", a_lr, 1'b1);
    step();
    a_pin = 8'hFF;
    for (int unsigned i = 0; i < FL; i++) begin
      #1;
      chk($sformatf("b2b_bit%0d", i), a_so, exp_bit(8'h1E, i, 1'b1));
      chk($sformatf("b2b_ready%0d", i), a_lr, (i == FL - 1));
      step();
    end
    a_lv = 1'b0;
    frame(1'b0, 8'hFF, "b2b2");

    // Reset after three bits, with a competing load request on the same edge
    load(1'b0, 8'h1E, "rmid");
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("rmid_bit%0d", i), a_so, exp_bit(8'h1E, i, 1'b1));
      step();
    end
    reset = 1'b1; a_lv = 1'b1; a_pin = 8'h55;
    step();
    reset = 1'b0; a_lv = 1'b0;
    #1;
    chk("rmid_valid", a_sv, 1'b0);
    chk("rmid_out", a_so, 1'b0);
    chk("rmid_last", a_fl, 1'b0);
    chk("rmid_ready", a_lr, 1'b1);
    step();
    #1;
    chk("idle_shift_ignored", a_sv, 1'b0);
    load(1'b0, 8'hA0, "after_rst");
    frame(1'b0, 8'hA0, "after_rst");

    // 8'h07: odd number of ones, so parity bit is 1 when enabled
    load(1'b0, 8'h07, "par_msb");
    frame(1'b0, 8'h07, "par_msb");
    load(1'b1, 8'h07, "par_lsb");
    frame(1'b1, 8'h07, "par_lsb");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_shift_param.md
Name: piso_shift_param

Overview:
- Parametrised parallel-in/serial-out shift register; next generation of the team's fixed single-bit PISO.
- Accepts a WIDTH-bit word via a valid/ready load handshake and serialises it one bit per enabled cycle.
- Bit order is selectable (MSB or LSB first); shift_en gives downstream back-pressure.
- Sits between a parallel data source and a serial link or transmitter.

Parameters:
- WIDTH, 8, word width in bits; legal range >= 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 first; 0 = bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- parallel_in  input  WIDTH  word to serialise; sampled on load accept.
- load_valid  input  1  source has a word on parallel_in.
- load_ready  output  1  block can accept a word this cycle.
- shift_en  input  1  sink consumes the current serial bit this cycle.
- serial_out  output  1  current serial bit.
- serial_valid  output  1  serial_out carries frame data.
- frame_last  output  1  current bit is the final bit of the frame.

Behaviour:
- Single clock domain; reset is synchronous and active-high. All state updates occur on rising clk.
- Reset state:
  - FSM in IDLE; bit counter = 0; shift register = 0.
  - Outputs: serial_out=0, serial_valid=0, frame_last=0, load_ready=1.
- FSM states: IDLE and SHIFT.
- Frame length: FLEN = WIDTH, or WIDTH+1 with the optional feature. Counter width is $clog2(FLEN+1).
- Load accept, on the edge where load_valid && load_ready:
  - shift register <= parallel_in; counter <= 0; state <= SHIFT.
  - First bit appears on serial_out in the next cycle (latency 1).
- Output decode, combinational from registers:
  - serial_valid = (state==SHIFT).
  - serial_out = selected end of the shift register (MSB if MSB_FIRST, else LSB). Forced to 0 in IDLE.
  - frame_last = serial_valid && counter==FLEN-1.
- Shift, in SHIFT with shift_en=1:
  - Register shifts toward the output end with 0 fill; counter increments.
  - If frame_last, state <= IDLE, unless a new load is accepted on the same edge.
- Stall: shift_en=0 in SHIFT holds the register, counter and serial_out unchanged, for any number of cycles.
- load_ready = (state==IDLE) || (frame_last && shift_en).
  - This allows gapless back-to-back frames: the new word is loaded on the same edge that consumes the last bit.
- load_valid while load_ready=0: ignored; the source must hold its word.
- shift_en in IDLE: ignored.
- Reset mid-frame: frame is aborted and the partial word discarded; reset state applies on the next edge. Reset has priority over a simultaneous load.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - On load accept, the even-parity bit (XOR reduction of parallel_in) is stored.
  - It is emitted as bit FLEN = WIDTH+1, after the data bits; frame_last asserts on the parity bit.
- Undefined: FLEN = WIDTH, with no parity storage or logic.

Decomposition:
- Package piso_pkg holds:
  - the state enum (PISO_IDLE, PISO_SHIFT);
  - a helper function for counter width.
- Sub-module piso_bit_cnt: frame bit counter with clear, enable and last-bit flag, parametrised by FLEN. Everything else stays in the top module.

Test Plan:
1. WIDTH=8, MSB_FIRST=1: load 8'h1E, shift_en held 1 -> serial_out 0,0,0,1,1,1,1,0 on cycles 1-8 after accept; frame_last only on cycle 8; serial_valid=0 on cycle 9.
2. MSB_FIRST=0: load 8'h1E -> serial_out 0,1,1,1,1,0,0,0.
3. Stall: load 8'h1E, drop shift_en for 3 cycles after the 2nd bit -> serial_out holds 0 and serial_valid stays 1 for those cycles; remaining 6 bits follow unchanged.
4. Back-to-back: load_valid held with 8'h1E then 8'hFF -> load_ready=1 during the last bit of the first frame; the second frame's first bit (1) follows with no gap.
5. Reset mid-frame: assert reset after 3 bits -> next cycle serial_valid=0, serial_out=0, load_ready=1; a subsequent load of 8'hA0 serialises cleanly as 1,0,1,0,0,0,0,0.
6. PISO_PARITY_EN defined: load 8'h07 -> 8 data bits followed by parity bit 1 as 9th bit; frame_last on the 9th bit.
